// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers.
//   ST_EMPTY / ST_ONE / ST_FULL : stage states; the encoding doubles as occupancy.
//   IDEX_W                      : width of the ID/EX bundle, used by instantiating stages.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int IDEX_W = 75;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, cleared only by reset.
// Ports:
//   CLK_PIPE : clock, rising edge
//   RST      : synchronous reset, active-low
//   INC      : count enable for this cycle
//   CNT      : current count; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK_PIPE,
  input  logic         RST,
  input  logic         INC,
  output logic [W-1:0] CNT
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of evaluation order between always blocks.
  always_ff @(posedge CLK_PIPE) begin
    if (!RST) begin
      CNT <= '0;
    end else if (INC && (CNT != {W{1'b1}})) begin
      CNT <= CNT + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid
// buffer, so IN_READY comes straight from a flop rather than from OUT_READY.
// Ports:
//   CLK_PIPE  : clock, rising edge
//   RST       : synchronous reset, active-low
//   FLUSH     : synchronous kill of all held entries (input that cycle dropped)
//   IN_VALID / IN_READY / IN_DATA    : upstream handshake and payload
//   OUT_VALID / OUT_READY / OUT_DATA : downstream handshake and payload
//   OCC       : entries held (0..2)
//   STALL_CNT : saturating count of cycles with OUT_VALID=1 and OUT_READY=0
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W         = IDEX_W,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic              CLK_PIPE,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [1:0]        OCC,
  output logic [CNT_W-1:0]  STALL_CNT
);

  logic [1:0]        state, state_next;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;
  logic              in_fire, out_fire;

  assign in_fire  = IN_VALID & in_ready_q;
  assign out_fire = OUT_VALID & OUT_READY;

  // NOTE: every variable driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    main_d     = main_q;
    skid_d     = skid_q;
    if (FLUSH) begin
      state_next = ST_EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d     = IN_DATA;
            state_next = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            // Streaming: the leaving entry is replaced in place.
            main_d = IN_DATA;
          end else if (in_fire) begin
            skid_d     = IN_DATA;
            state_next = ST_FULL;
          end else if (out_fire) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // IN_READY is low here, so only the drain side can move.
          if (out_fire) begin
            main_d     = skid_q;
            state_next = ST_ONE;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  // NOTE: the data registers are reset as well as the control state, because
  // OUT_DATA is observable while OUT_VALID=0 and must read as zero after reset.
  always_ff @(posedge CLK_PIPE) begin
    if (!RST) begin
      state      <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_next;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_next != ST_FULL);
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = (state != ST_EMPTY);
  assign OUT_DATA  = main_q;
  assign OCC       = state;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .CLK_PIPE (CLK_PIPE),
    .RST      (RST),
    .INC      (OUT_VALID & ~OUT_READY),
    .CNT      (STALL_CNT)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances share one stimulus stream, one with
// data clearing on flush and one without, both with a 4-bit stall counter.
// A queue-style model predicts every output each cycle; directed steps add
// hand-computed literal expectations.
module tb_pipe_stage_reg;

  localparam int DW   = pipe_pkg::IDEX_W;
  localparam int CW   = 4;
  localparam int SMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          in_ready  [2];
  logic          out_valid [2];
  logic [DW-1:0] out_data  [2];
  logic [1:0]    occ       [2];
  logic [CW-1:0] stall_cnt [2];

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b1), .CNT_W(CW)) u_clr (
    .CLK_PIPE (clk),          .RST       (rst),          .FLUSH    (flush),
    .IN_VALID (in_valid),     .IN_READY  (in_ready[0]),  .IN_DATA  (in_data),
    .OUT_VALID(out_valid[0]), .OUT_READY (out_ready),    .OUT_DATA (out_data[0]),
    .OCC      (occ[0]),       .STALL_CNT (stall_cnt[0])
  );

  pipe_stage_reg #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b0), .CNT_W(CW)) u_keep (
    .CLK_PIPE (clk),          .RST       (rst),          .FLUSH    (flush),
    .IN_VALID (in_valid),     .IN_READY  (in_ready[1]),  .IN_DATA  (in_data),
    .OUT_VALID(out_valid[1]), .OUT_READY (out_ready),    .OUT_DATA (out_data[1]),
    .OCC      (occ[1]),       .STALL_CNT (stall_cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: each instance is a FIFO of at most two entries plus the value the
  // output register last held (what OUT_DATA shows while nothing is valid).
  logic [DW-1:0] fifo  [2][2];
  int            cnt   [2];
  logic [DW-1:0] stale [2];
  int            m_stall [2];
  logic          m_ready;
  bit            started = 0;

  always @(posedge clk) begin
    bit acc, pop;
    acc = in_valid && m_ready;
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        cnt[i]     = 0;
        stale[i]   = '0;
        m_stall[i] = 0;
      end else begin
        pop = (cnt[i] > 0) && out_ready;
        if (cnt[i] > 0 && !out_ready && m_stall[i] < SMAX) m_stall[i]++;
        if (flush) begin
          if (cnt[i] > 0) stale[i] = fifo[i][0];
          if (i == 0) stale[i] = '0;
          cnt[i] = 0;
        end else begin
          if (pop) begin
            stale[i]   = fifo[i][0];
            fifo[i][0] = fifo[i][1];
            cnt[i]--;
          end
          if (acc) begin
            fifo[i][cnt[i]] = in_data;
            cnt[i]++;
          end
        end
      end
    end
    m_ready = rst && (flush || cnt[0] < 2);
    started = 1;
  end

  // Compare every cycle, half a period after the edge.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("m_out_valid[%0d]", i), out_valid[i], cnt[i] > 0);
        check($sformatf("m_out_data[%0d]", i), out_data[i], (cnt[i] > 0) ? fifo[i][0] : stale[i]);
        check($sformatf("m_occ[%0d]", i), occ[i], cnt[i]);
        check($sformatf("m_in_ready[%0d]", i), in_ready[i], m_ready);
        check($sformatf("m_stall[%0d]", i), stall_cnt[i], m_stall[i]);
      end
    end
  end

  // Record what leaves instance 0, for order / loss / duplication checks.
  logic [DW-1:0] seen [$];
  always @(posedge clk) begin
    if (rst && !flush && out_valid[0] && out_ready) seen.push_back(out_data[0]);
  end

  task automatic send(input logic [DW-1:0] d);
    bit acc;
    acc      = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = in_ready[0];
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("send_accept", acc, 1'b1);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 'h1234; out_ready = 1'b0;

    // Reset held for three edges with input presented.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_out_valid", out_valid[i], 1'b0);
      check("rst_in_ready", in_ready[i], 1'b0);
      check("rst_occ", occ[i], 2'd0);
      check("rst_out_data", out_data[i], '0);
      check("rst_stall", stall_cnt[i], '0);
    end
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("rel_in_ready", in_ready[0], 1'b1);

    // Streaming at one item per cycle.
    out_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      in_valid = 1'b1;
      in_data  = DW'(v);
      @(negedge clk);
      check("stream_data", out_data[0], v);
      check("stream_occ", occ[0], 2'd1);
      check("stream_ready", in_ready[0], 1'b1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_drain_occ", occ[0], 2'd0);

    // Backpressure fills the skid; CC waits for IN_READY.
    seen.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 'hAA; @(negedge clk);
    in_data = 'hBB; @(negedge clk);
    in_valid = 1'b0;
    check("bp_occ", occ[0], 2'd2);
    check("bp_in_ready", in_ready[0], 1'b0);
    check("bp_head", out_data[0], 'hAA);
    out_ready = 1'b1;
    send('hCC);
    @(negedge clk);
    check("bp_count", seen.size(), 3);
    if (seen.size() == 3) begin
      check("bp_order0", seen[0], 'hAA);
      check("bp_order1", seen[1], 'hBB);
      check("bp_order2", seen[2], 'hCC);
    end
    check("bp_empty", occ[0], 2'd0);

    // Flush a full stage with an input offered in the same cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 'h11; @(negedge clk);
    in_data = 'h22; @(negedge clk);
    check("fl_full", occ[0], 2'd2);
    seen.delete();
    flush = 1'b1; in_data = 'h33;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("fl_occ", occ[0], 2'd0);
    check("fl_valid", out_valid[0], 1'b0);
    check("fl_data_clr", out_data[0], '0);
    check("fl_data_keep", out_data[1], 'h11);
    check("fl_valid_keep", out_valid[1], 1'b0);
    check("fl_in_ready", in_ready[0], 1'b1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("fl_nothing_out", seen.size(), 0);

    // Stall counter saturation, immune to flush, cleared by reset.
    rst = 1'b0; @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b0;
    send('h44);
    repeat (20) @(negedge clk);
    check("sat_clr", stall_cnt[0], 4'd15);
    check("sat_keep", stall_cnt[1], 4'd15);
    flush = 1'b1; @(negedge clk);
    flush = 1'b0;
    check("sat_after_flush", stall_cnt[0], 4'd15);
    @(negedge clk);
    check("sat_hold", stall_cnt[0], 4'd15);
    rst = 1'b0; @(negedge clk);
    check("sat_reset", stall_cnt[0], 4'd0);
    rst = 1'b1;

    // Reset while full: old data must never reappear.
    send('h55);
    send('h66);
    check("mid_full", occ[0], 2'd2);
    rst = 1'b0; @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("mid_occ", occ[i], 2'd0);
      check("mid_valid", out_valid[i], 1'b0);
      check("mid_data", out_data[i], '0);
      check("mid_in_ready", in_ready[i], 1'b0);
    end
    seen.delete();
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_nothing_out", seen.size(), 0);
    send('h77);
    check("mid_new_data", out_data[0], 'h77);
    check("mid_new_occ", occ[0], 2'd1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
